// File: rtl/tb_hci_mem_pkg.sv
// Shared constants, response type and LFSR step for the HCI latency memory model.
// The LFSR is a 16-bit right-shift Galois generator for x^16+x^14+x^13+x^11+1.
package tb_hci_mem_pkg;

    localparam int unsigned      LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;
    localparam int unsigned      STALL_W   = 10;
    localparam int unsigned      RESP_DW   = 32;

    // Default-width response; the memory top declares the same shape at its own DW.
    typedef struct packed {
        logic [RESP_DW-1:0] data;
        logic               err;
    } resp_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/tb_hci_latency_memory_if.sv
// TCDM target-side bundle for the latency memory: request, grant, response and counters.
// The memory binds to the slave modport; the driving testbench/DUT side uses master.
interface tb_hci_latency_memory_if #(
    parameter int unsigned MP = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic                         enable_i;
    logic                         stallable_i;
    logic [9:0]                   stall_thr_i;
    logic [MP-1:0]                req_i;
    logic [MP-1:0]                gnt_o;
    logic [MP-1:0][AW-1:0]        add_i;
    logic [MP-1:0]                wen_i;
    logic [MP-1:0][DW/8-1:0]      be_i;
    logic [MP-1:0][DW-1:0]        data_i;
    logic [MP-1:0][DW-1:0]        r_data_o;
    logic [MP-1:0]                r_valid_o;
    logic [MP-1:0]                err_o;
    logic [MP-1:0][31:0]          cnt_rd_o;
    logic [MP-1:0][31:0]          cnt_wr_o;
    logic [MP-1:0][31:0]          cnt_stall_o;

    modport master (
        output enable_i, stallable_i, stall_thr_i, req_i, add_i, wen_i, be_i, data_i,
        input  gnt_o, r_data_o, r_valid_o, err_o, cnt_rd_o, cnt_wr_o, cnt_stall_o
    );

    modport slave (
        input  enable_i, stallable_i, stall_thr_i, req_i, add_i, wen_i, be_i, data_i,
        output gnt_o, r_data_o, r_valid_o, err_o, cnt_rd_o, cnt_wr_o, cnt_stall_o
    );
endinterface

// File: rtl/tb_hci_mem_lfsr.sv
// One seeded Galois LFSR; holds its seed while in reset and steps on every enabled cycle.
// Only the low OUT_W bits are exported since the stall compare uses no more than that.
module tb_hci_mem_lfsr
    import tb_hci_mem_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int unsigned       OUT_W = STALL_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_state
);
    // An all-zero state would lock the generator, so a zero seed becomes 1.
    localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= SEED_NZ;
        else if (i_en)
            r_state <= lfsr_next(r_state);
    end

    assign o_state = r_state[OUT_W-1:0];

endmodule

// File: rtl/tb_hci_latency_memory.sv
// Multi-port TCDM word memory with fixed response latency, LFSR-driven stalls and
// fixed-priority same-word arbitration. Per-port counters exist only with TB_MEM_PERF_CNT_EN.
module tb_hci_latency_memory
    import tb_hci_mem_pkg::*;
#(
    parameter int unsigned   MP          = 4,
    parameter int unsigned   DW          = 32,
    parameter int unsigned   AW          = 32,
    parameter int unsigned   MEMORY_SIZE = 1024,
    parameter logic [AW-1:0] BASE_ADDR   = '0,
    parameter int unsigned   LATENCY     = 1,
    parameter logic [15:0]   SEED        = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    tb_hci_latency_memory_if.slave   tcdm
);
    localparam int unsigned NB   = DW / 8;
    localparam int unsigned OFFB = $clog2(NB);
    localparam int unsigned IW   = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } port_resp_t;

    logic [DW-1:0]            r_mem [MEMORY_SIZE];

    logic [MP-1:0][STALL_W-1:0] w_lfsr;
    logic [MP-1:0]              w_stall;
    logic [MP-1:0]              w_part;
    logic [MP-1:0]              w_conf;
    logic [MP-1:0]              w_gnt;
    logic [MP-1:0]              w_oor;
    logic [MP-1:0][AW-1:0]      w_word;
    logic [MP-1:0][IW-1:0]      w_idx;
    logic [MP-1:0][DW-1:0]      w_rdw;
    logic [MP-1:0][DW-1:0]      w_merge;
    port_resp_t [MP-1:0]        w_resp;
    logic [MP-1:0]              w_rvalid;
    logic [MP-1:0]              w_err;
    logic [MP-1:0][DW-1:0]      w_rdata;

    for (genvar p = 0; p < MP; p++) begin : g_port
        tb_hci_mem_lfsr #(
            .SEED  (SEED ^ LFSR_W'(p)),
            .OUT_W (STALL_W)
        ) u_lfsr (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_en    (1'b1),
            .o_state (w_lfsr[p])
        );

        assign w_stall[p] = tcdm.stallable_i & (w_lfsr[p] < tcdm.stall_thr_i);
        assign w_word[p]  = (tcdm.add_i[p] - BASE_ADDR) >> OFFB;
        assign w_oor[p]   = (tcdm.add_i[p] < BASE_ADDR) | (w_word[p] >= AW'(MEMORY_SIZE));
        assign w_idx[p]   = w_word[p][IW-1:0];
        assign w_rdw[p]   = r_mem[w_idx[p]];

        for (genvar b = 0; b < NB; b++) begin : g_byte
            assign w_merge[p][b*8 +: 8] = tcdm.be_i[p][b] ? tcdm.data_i[p][b*8 +: 8]
                                                          : w_rdw[p][b*8 +: 8];
        end

        // Writes answer with the merged word; out-of-range accesses answer zero with err.
        assign w_resp[p].data = w_oor[p]       ? '0 :
                                tcdm.wen_i[p]  ? w_rdw[p] : w_merge[p];
        assign w_resp[p].err  = w_oor[p];

        logic [LATENCY:1]       r_vld_pipe;
        port_resp_t [LATENCY:1] r_resp_pipe;

        // Payload only moves with a valid token, so the last stage holds the last response.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_vld_pipe  <= '0;
                r_resp_pipe <= '0;
            end else begin
                for (int s = LATENCY; s > 1; s--) begin
                    r_vld_pipe[s] <= r_vld_pipe[s-1];
                    if (r_vld_pipe[s-1])
                        r_resp_pipe[s] <= r_resp_pipe[s-1];
                end
                r_vld_pipe[1] <= w_gnt[p];
                if (w_gnt[p])
                    r_resp_pipe[1] <= w_resp[p];
            end
        end

        assign w_rvalid[p] = r_vld_pipe[LATENCY];
        assign w_err[p]    = r_vld_pipe[LATENCY] & r_resp_pipe[LATENCY].err;
        assign w_rdata[p]  = r_resp_pipe[LATENCY].data;
    end

    assign w_part = tcdm.req_i & ~w_stall;

    // Lower port index wins a same-word collision, whatever the read/write mix.
    always_comb begin
        w_conf = '0;
        for (int j = 1; j < MP; j++)
            for (int i = 0; i < j; i++)
                if (w_part[i] && w_part[j] && (w_word[i] == w_word[j]))
                    w_conf[j] = 1'b1;
    end

    assign w_gnt = tcdm.req_i & {MP{tcdm.enable_i}} & ~w_stall & ~w_conf & {MP{~rst_i}};

    // Memory is deliberately left out of reset; the bench preloads it.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++)
            if (w_gnt[p] && !tcdm.wen_i[p] && !w_oor[p])
                r_mem[w_idx[p]] <= w_merge[p];
    end

    assign tcdm.gnt_o     = w_gnt;
    assign tcdm.r_valid_o = w_rvalid;
    assign tcdm.err_o     = w_err;
    assign tcdm.r_data_o  = w_rdata;

`ifdef TB_MEM_PERF_CNT_EN
    logic [MP-1:0][31:0] r_cnt_rd;
    logic [MP-1:0][31:0] r_cnt_wr;
    logic [MP-1:0][31:0] r_cnt_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt_rd    <= '0;
            r_cnt_wr    <= '0;
            r_cnt_stall <= '0;
        end else begin
            for (int p = 0; p < MP; p++) begin
                if (w_gnt[p] && tcdm.wen_i[p])
                    r_cnt_rd[p] <= r_cnt_rd[p] + 32'd1;
                if (w_gnt[p] && !tcdm.wen_i[p])
                    r_cnt_wr[p] <= r_cnt_wr[p] + 32'd1;
                if (tcdm.req_i[p] && !w_gnt[p])
                    r_cnt_stall[p] <= r_cnt_stall[p] + 32'd1;
            end
        end
    end

    assign tcdm.cnt_rd_o    = r_cnt_rd;
    assign tcdm.cnt_wr_o    = r_cnt_wr;
    assign tcdm.cnt_stall_o = r_cnt_stall;
`else
    assign tcdm.cnt_rd_o    = '0;
    assign tcdm.cnt_wr_o    = '0;
    assign tcdm.cnt_stall_o = '0;
`endif

endmodule
